pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits (legal range 1..512).
REQ-002 The block SHALL have parameter NOP_VALUE, WIDTH bits, default all-zero, giving the bubble payload shown on reset, flush or empty.
REQ-003 The block SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port flush  input  1  discard all held entries.
REQ-006 The block SHALL have port hold  input  1  freeze all state and block both transfer directions.
REQ-007 The block SHALL have port in_valid  input  1  upstream payload present.
REQ-008 The block SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 The block SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 The block SHALL have port out_valid  output  1  out_data is a live entry.
REQ-011 The block SHALL have port out_data  output  WIDTH  oldest held payload, or NOP_VALUE when empty.
REQ-012 The block SHALL have port out_ready  input  1  downstream consumes out_data this cycle.

Function
REQ-013 Storage SHALL be two entries, main (drives out_data) and skid; occupancy is 0, 1 or 2; main always holds the oldest entry.
REQ-014 Accept SHALL be defined as in_valid && in_ready; consume SHALL be defined as out_valid && out_ready.
REQ-015 in_ready SHALL equal !skid_valid && !hold && !flush, with no combinational path from out_ready.
REQ-016 out_valid SHALL equal main_valid && !hold.
REQ-017 out_data SHALL equal NOP_VALUE whenever main_valid is 0.
REQ-018 Latency SHALL be 1 cycle: data accepted into an empty stage appears on out_data with out_valid=1 on the next cycle.
REQ-019 Sustained throughput SHALL be one transfer per cycle when out_ready is held at 1.
REQ-020 Occupancy 0, accept: the payload SHALL be loaded into main.
REQ-021 Occupancy 1, accept without consume: the payload SHALL be loaded into skid; in_ready falls on the next cycle.
REQ-022 Occupancy 1, accept with consume: the payload SHALL be loaded into main, and occupancy remains 1.
REQ-023 Occupancy 1, consume without accept: main SHALL be emptied.
REQ-024 Occupancy 2, consume: skid SHALL move to main and skid is emptied; accept is impossible because in_ready=0.
REQ-025 The block SHALL never drop, duplicate or reorder entries.
REQ-026 hold=1 (and flush=0): every register SHALL retain its value; no accept or consume occurs.
REQ-027 flush=1 SHALL clear both valid bits and set both payload registers to NOP_VALUE on the next edge.
REQ-028 flush=1 SHALL take priority over hold, accept and consume, and in_data on the flush cycle is discarded.
REQ-029 After flush, in_ready SHALL be 1 on the first cycle with flush=0 and hold=0.

Reset
REQ-030 RST=1 at a rising edge SHALL force main_valid=0, skid_valid=0, and both payloads to NOP_VALUE.
REQ-031 During and after reset, outputs SHALL read out_valid=0, out_data=NOP_VALUE, and in_ready=1 (when hold=0 and flush=0).
REQ-032 RST SHALL take priority over flush and hold, and reset mid-transfer SHALL discard all entries.

Configuration
REQ-033 With macro PIPE_STAGE_PERF_EN defined, the block SHALL add output stall_cnt (16 bits), counting cycles with main_valid && !out_ready && !hold.
REQ-034 With PIPE_STAGE_PERF_EN defined, stall_cnt SHALL saturate at 0xFFFF and be cleared by RST or flush.
REQ-035 Without PIPE_STAGE_PERF_EN, stall_cnt and its logic SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-036 Scenario: WIDTH=32, out_ready=1, stream 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, each 1 cycle after its accept, in_ready constant 1.
REQ-037 Scenario: out_ready=0, push 0xA then 0xB -> in_ready=0 after the 2nd accept; release out_ready -> outputs 0xA then 0xB; 0xC offered while full is not accepted.
REQ-038 Scenario: occupancy 2 (0xA, 0xB), assert flush 1 cycle with in_valid=1, in_data=0xC -> out_valid=0, out_data=NOP_VALUE, 0xC never appears, in_ready=1 next cycle.
REQ-039 Scenario: occupancy 1 (0x5), hold=1 for 3 cycles with in_valid=1, out_ready=1 -> out_valid=0, in_ready=0, and 0x5 is delivered exactly once after hold drops.
REQ-040 Scenario: RST asserted with occupancy 2 while flush=1 and hold=1 -> after the edge, out_valid=0, in_ready=1, out_data=NOP_VALUE (0x00000000 at default).
REQ-041 Scenario: PIPE_STAGE_PERF_EN defined, out_valid=1 and out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF; one flush -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Handshake bundle for pipe_stage: upstream valid/ready/data and downstream
// valid/ready/data. The slave modport is the stage's view; master is the
// view of whatever drives the stage and consumes its output.
interface pipe_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_stage.sv
// pipe_stage: two-entry skid-buffered pipeline register (main + skid).
// in_ready depends only on registered state, hold and flush, never on
// out_ready, so the stage breaks the ready path between neighbours.
// Optional build macro PIPE_STAGE_PERF_EN adds a saturating 16-bit
// stall_cnt output counting cycles where a live entry waits downstream.
module pipe_stage #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        hold,
    pipe_stage_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             accept;
    logic             consume;

    assign bus.in_ready  = !skid_valid_q && !hold && !flush;
    assign bus.out_valid = main_valid_q && !hold;
    assign bus.out_data  = main_valid_q ? main_data_q : NOP_VALUE;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;

    // Next-state for both entries; main always holds the oldest payload.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = NOP_VALUE;
            skid_data_d  = NOP_VALUE;
        end else if (!hold) begin
            if (main_valid_q) begin
                if (consume) begin
                    if (skid_valid_q) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end else if (accept) begin
                        main_data_d  = bus.in_data;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    skid_data_d  = bus.in_data;
                    skid_valid_d = 1'b1;
                end
            end else if (accept) begin
                main_data_d  = bus.in_data;
                main_valid_d = 1'b1;
            end
        end
    end

    // Entry registers; reset outranks flush and hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= NOP_VALUE;
            skid_data_q  <= NOP_VALUE;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count stalled cycles of a live entry, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = 16'h0000;
        end else if (main_valid_q && !bus.out_ready && !hold && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end
    end

    // Stall counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage (WIDTH=32). A queue holding at most two
// payloads models the stage: outputs are predicted from the queue head and
// its length, and each clock edge pops on consume and pushes on accept.
module tb_pipe_stage;

    localparam int unsigned W   = 32;
    localparam logic [W-1:0] NOP = '0;

    logic clk;
    logic rst;
    logic flush;
    logic hold;

    int checks;
    int errors;

    logic [W-1:0] mq[$];

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stallCnt;
`endif

    pipe_stage_if #(.WIDTH(W)) bus ();

    pipe_stage #(
        .WIDTH     (W),
        .NOP_VALUE (NOP)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .flush (flush),
        .hold  (hold),
        .bus   (bus)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stallCnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit expReady();
        return (mq.size() < 2) && !hold && !flush;
    endfunction

    function automatic bit expValid();
        return (mq.size() > 0) && !hold;
    endfunction

    function automatic logic [W-1:0] expData();
        if (mq.size() > 0) return mq[0];
        return NOP;
    endfunction

    // Drive one cycle's inputs and move to the sampling point (negedge).
    task automatic applyStimulus(input bit r, input bit f, input bit h,
                                 input bit iv, input logic [W-1:0] d, input bit ordy);
        rst           = r;
        flush         = f;
        hold          = h;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(negedge clk);
    endtask

    // Take the rising edge and update the queue model with the same inputs.
    task automatic advance();
        bit acc;
        bit con;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else if (!hold) begin
            acc = bus.in_valid && (mq.size() < 2);
            con = (mq.size() > 0) && bus.out_ready;
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(bus.in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1, 0, 0, 1, 32'hDEAD_BEEF, 0);
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== NOP) begin
            errors++; $display("[TB] FAIL reset_data got %h expected %h", bus.out_data, NOP);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 1, W'(i + 1), 1);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL b2b_ready[%0d] got %b expected 1", i, bus.in_ready);
            end
            if (i > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== W'(i)) begin
                    errors++;
                    $display("[TB] FAIL b2b_out[%0d] got %b/%h expected 1/%h", i, bus.out_valid, bus.out_data, W'(i));
                end
            end
            advance();
        end
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h8) begin
            errors++; $display("[TB] FAIL b2b_last got %b/%h expected 1/00000008", bus.out_valid, bus.out_data);
        end
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_drained got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_skid();
        applyStimulus(0, 0, 0, 1, 32'hA, 0);
        advance();
        applyStimulus(0, 0, 0, 1, 32'hB, 0);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_data !== 32'hA) begin
            errors++; $display("[TB] FAIL skid_second got ready %b data %h expected 1/0000000a", bus.in_ready, bus.out_data);
        end
        advance();
        applyStimulus(0, 0, 0, 1, 32'hC, 0);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL skid_full_ready got %b expected 0", bus.in_ready);
        end
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA) begin
            errors++; $display("[TB] FAIL skid_first_out got %b/%h expected 1/0000000a", bus.out_valid, bus.out_data);
        end
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB) begin
            errors++; $display("[TB] FAIL skid_second_out got %b/%h expected 1/0000000b", bus.out_valid, bus.out_data);
        end
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== NOP) begin
            errors++; $display("[TB] FAIL skid_no_c got %b/%h expected 0/%h", bus.out_valid, bus.out_data, NOP);
        end
        advance();
    endtask

    task automatic test_flush();
        applyStimulus(0, 0, 0, 1, 32'hA, 0);
        advance();
        applyStimulus(0, 0, 0, 1, 32'hB, 0);
        advance();
        applyStimulus(0, 1, 0, 1, 32'hC, 0);
        advance();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 32'h0, 1);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== NOP || bus.in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL flush_empty[%0d] got valid %b data %h ready %b expected 0/%h/1", i, bus.out_valid, bus.out_data, bus.in_ready, NOP);
            end
            advance();
        end
    endtask

    task automatic test_hold();
        applyStimulus(0, 0, 0, 1, 32'h5, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 1, 32'h77, 1);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL hold_block[%0d] got valid %b ready %b expected 0/0", i, bus.out_valid, bus.in_ready);
            end
            advance();
        end
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5) begin
            errors++; $display("[TB] FAIL hold_release got %b/%h expected 1/00000005", bus.out_valid, bus.out_data);
        end
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_once got %b expected 0", bus.out_valid);
        end
        advance();
    endtask

    task automatic test_reset_priority();
        applyStimulus(0, 0, 0, 1, 32'hA, 0);
        advance();
        applyStimulus(0, 0, 0, 1, 32'hB, 0);
        advance();
        applyStimulus(1, 1, 1, 1, 32'hC, 1);
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_prio got valid %b ready %b data %h expected 0/1/00000000", bus.out_valid, bus.in_ready, bus.out_data);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                          $urandom_range(0, 5) == 0, 1'($urandom), $urandom, 1'($urandom));
            checks++;
            if (bus.in_ready !== expReady()) begin
                errors++; $display("[TB] FAIL rand_ready[%0d] got %b expected %b", i, bus.in_ready, expReady());
            end
            checks++;
            if (bus.out_valid !== expValid()) begin
                errors++; $display("[TB] FAIL rand_valid[%0d] got %b expected %b", i, bus.out_valid, expValid());
            end
            checks++;
            if (bus.out_data !== expData()) begin
                errors++; $display("[TB] FAIL rand_data[%0d] got %h expected %h", i, bus.out_data, expData());
            end
            advance();
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        advance();
        applyStimulus(0, 0, 0, 1, 32'h99, 0);
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) advance();
        checks++;
        if (stallCnt !== 16'd5) begin
            errors++; $display("[TB] FAIL perf_count got %0d expected 5", stallCnt);
        end
        for (int i = 0; i < 70000; i++) advance();
        checks++;
        if (stallCnt !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL perf_saturate got %h expected ffff", stallCnt);
        end
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        advance();
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checks++;
        if (stallCnt !== 16'h0000) begin
            errors++; $display("[TB] FAIL perf_flush got %h expected 0000", stallCnt);
        end
        advance();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        flush = 1'b0;
        hold = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        advance();
        test_back_to_back();
        advance();
        test_skid();
        test_flush();
        test_hold();
        test_reset_priority();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
